// File: rtl/pipe_delay_line_pkg.sv
// Shared types and constants for pipe_delay_line.
// Optional parity storage is enabled by defining PIPE_DELAY_LINE_PARITY_EN.
package pipe_delay_line_pkg;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 64;
  localparam int unsigned DEPTH_MIN = 1;
  localparam int unsigned DEPTH_MAX = 32;

  // Data is held at full WIDTH_MAX; bits above WIDTH are always zero and trim away.
  typedef struct packed {
    logic                 valid;
`ifdef PIPE_DELAY_LINE_PARITY_EN
    logic                 parity;
`endif
    logic [WIDTH_MAX-1:0] data;
  } stage_t;

  function automatic int unsigned fill_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_delay_line_stage.sv
// One register stage of the delay line: flush and enable handling around a stage record.
// Carries the parity bit when PIPE_DELAY_LINE_PARITY_EN is defined.
module delay_stage
  import pipe_delay_line_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   flush,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_delay_line.sv
// Enable-gated, flushable pipeline delay line of DEPTH stages with a registered fill count.
// Define PIPE_DELAY_LINE_PARITY_EN to carry per-stage even parity and expose par_err.
module pipe_delay_line
  import pipe_delay_line_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
`ifdef PIPE_DELAY_LINE_PARITY_EN
  output logic                          par_err,
`endif
  output logic [fill_width(DEPTH)-1:0]  fill_count
);

  localparam int unsigned FW = fill_width(DEPTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_params
    $error("pipe_delay_line: WIDTH or DEPTH out of range");
  end

  stage_t          stage_in;
  stage_t          d [DEPTH];
  stage_t          q [DEPTH];
  logic [FW-1:0]   next_count;
  logic            unused_hi;

  always_comb begin
    stage_in                  = '0;
    stage_in.valid            = in_valid;
    stage_in.data[WIDTH-1:0]  = in_data;
`ifdef PIPE_DELAY_LINE_PARITY_EN
    stage_in.parity           = ^in_data;
`endif
  end

  assign d[0] = stage_in;

  for (genvar k = 0; k < DEPTH; k++) begin : g_chain
    if (k > 0) begin : g_link
      assign d[k] = q[k-1];
    end
    delay_stage u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .flush (flush),
      .d     (d[k]),
      .q     (q[k])
    );
  end

  // Count the valid bits about to be loaded so fill_count tracks the stages edge-for-edge.
  always_comb begin
    next_count = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      next_count = next_count + FW'(d[k].valid);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count <= '0;
    end else if (flush) begin
      fill_count <= '0;
    end else if (en) begin
      fill_count <= next_count;
    end
  end

`ifdef PIPE_DELAY_LINE_PARITY_EN
  // Checked as the sample enters the last stage so par_err lines up with its out_valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else begin
      par_err <= en && !flush && d[DEPTH-1].valid &&
                 ((^d[DEPTH-1].data) != d[DEPTH-1].parity);
    end
  end
`endif

  assign out_valid = q[DEPTH-1].valid;
  assign out_data  = q[DEPTH-1].data[WIDTH-1:0];
  assign unused_hi = ^q[DEPTH-1].data;

endmodule

// File: tb/tb_pipe_delay_line.sv
// Scoreboard bench for pipe_delay_line (WIDTH=8, DEPTH=4) plus a DEPTH=1 DFF equivalence run.
// Parity checks are compiled in when PIPE_DELAY_LINE_PARITY_EN is defined.
module tb_pipe_delay_line;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, flush, in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] fill_count;

  logic       d_in;
  logic       d_out_valid;
  logic       d_out_data;
  logic       d_fill;
  logic       ref_q;

`ifdef PIPE_DELAY_LINE_PARITY_EN
  logic       par_err;
  logic       d_par_err;
`endif

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  logic       adv_q;

  always #5 clk = ~clk;

  pipe_delay_line #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
`ifdef PIPE_DELAY_LINE_PARITY_EN
    .par_err    (par_err),
`endif
    .fill_count (fill_count)
  );

  pipe_delay_line #(.WIDTH(1), .DEPTH(1)) u_dff (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (1'b1),
    .flush      (1'b0),
    .in_valid   (1'b1),
    .in_data    (d_in),
    .out_valid  (d_out_valid),
    .out_data   (d_out_data),
`ifdef PIPE_DELAY_LINE_PARITY_EN
    .par_err    (d_par_err),
`endif
    .fill_count (d_fill)
  );

  // Reference single flip-flop for the DEPTH=1 equivalence run.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_q <= 1'b0;
    else        ref_q <= d_in;
  end

  // Records whether the last edge advanced the line, so a held output is not consumed twice.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) adv_q <= 1'b0;
    else        adv_q <= en && !flush;
  end

  always @(negedge clk) begin
    if (rst_n && adv_q && out_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL out_data: unexpected output %02h, scoreboard empty", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          miscompares++;
          $display("FAIL out_data: got %02h expected %02h", out_data, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic f, input logic v, input logic [7:0] dat);
    en = e; flush = f; in_valid = v; in_data = dat;
    if (e && !f && v) exp_q.push_back(dat);
    @(posedge clk);
    #1;
    if (f) exp_q.delete();
  endtask

  task automatic step_fc(input logic e, input logic f, input logic v, input logic [7:0] dat,
                         input logic [2:0] fc);
    step(e, f, v, dat);
    check("fill_count", 64'(fill_count), 64'(fc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; d_in = 1'b0;
    #2;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_fill", 64'(fill_count), 64'd0);
    #10 rst_n = 1'b1;

    // Basic stream: three valid samples then bubbles.
    step_fc(1, 0, 1, 8'h11, 3'd1);
    step_fc(1, 0, 1, 8'h22, 3'd2);
    step_fc(1, 0, 1, 8'h33, 3'd3);
    step_fc(1, 0, 0, 8'h00, 3'd3);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("latency_out_data", 64'(out_data), 64'h11);
    step_fc(1, 0, 0, 8'h00, 3'd2);
    step_fc(1, 0, 0, 8'h00, 3'd1);
    step_fc(1, 0, 0, 8'h00, 3'd0);
    check("drained_out_valid", 64'(out_valid), 64'd0);

    // Same stream with enable low for two cycles.
    step_fc(1, 0, 1, 8'h11, 3'd1);
    step_fc(1, 0, 1, 8'h22, 3'd2);
    step_fc(0, 0, 1, 8'h99, 3'd2);
    step_fc(0, 0, 1, 8'h98, 3'd2);
    step_fc(1, 0, 1, 8'h33, 3'd3);
    step_fc(1, 0, 0, 8'h00, 3'd3);
    step_fc(1, 0, 0, 8'h00, 3'd2);
    step_fc(1, 0, 0, 8'h00, 3'd3 - 3'd2);
    step_fc(1, 0, 0, 8'h00, 3'd0);

    // Fill past DEPTH, then flush with enable low.
    step_fc(1, 0, 1, 8'h41, 3'd1);
    step_fc(1, 0, 1, 8'h42, 3'd2);
    step_fc(1, 0, 1, 8'h43, 3'd3);
    step_fc(1, 0, 1, 8'h44, 3'd4);
    step_fc(1, 0, 1, 8'h45, 3'd4);
    step_fc(1, 0, 1, 8'h46, 3'd4);
    step_fc(0, 1, 1, 8'h55, 3'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_data", 64'(out_data), 64'd0);
    step_fc(1, 0, 0, 8'h00, 3'd0);

    // Asynchronous reset mid-cycle with three valid stages.
    step_fc(1, 0, 1, 8'h61, 3'd1);
    step_fc(1, 0, 1, 8'h62, 3'd2);
    step_fc(1, 0, 1, 8'h63, 3'd3);
    #3 rst_n = 1'b0;
    #2;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_data", 64'(out_data), 64'd0);
    check("async_rst_fill", 64'(fill_count), 64'd0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    step_fc(1, 0, 1, 8'h77, 3'd1);
    check("post_rst_wait1", 64'(out_valid), 64'd0);
    step_fc(1, 0, 0, 8'h00, 3'd1);
    check("post_rst_wait2", 64'(out_valid), 64'd0);
    step_fc(1, 0, 0, 8'h00, 3'd1);
    check("post_rst_wait3", 64'(out_valid), 64'd0);
    step_fc(1, 0, 0, 8'h00, 3'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd1);
    check("post_rst_out_data", 64'(out_data), 64'h77);
    step_fc(1, 0, 0, 8'h00, 3'd0);

`ifdef PIPE_DELAY_LINE_PARITY_EN
    // Corrupt a valid 0xA5 while it sits in stage 2.
    step(1, 0, 1, 8'hA5);
    exp_q[exp_q.size()-1] = 8'hA4;
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    force dut.g_chain[2].u_stage.q.data = 64'hA4;
    step(1, 0, 0, 8'h00);
    release dut.g_chain[2].u_stage.q.data;
    check("par_err_set", 64'(par_err), 64'd1);
    step(1, 0, 0, 8'h00);
    check("par_err_one_cycle", 64'(par_err), 64'd0);
    step(1, 0, 1, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      check("par_err_clean", 64'(par_err), 64'd0);
      step(1, 0, 0, 8'h00);
    end
    check("par_err_clean_end", 64'(par_err), 64'd0);
`endif

    en = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      d_in = 1'($urandom);
      @(posedge clk);
      #1;
      check("dff_equiv", 64'(d_out_data), 64'(ref_q));
    end
    check("dff_out_valid", 64'(d_out_valid), 64'd1);
    check("dff_fill", 64'(d_fill), 64'd1);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
